cf_pio_timing: RTL and testbench
================================

CF_PIO_TIMING -- requirements
Module: cf_pio_timing

Interface
REQ-001 SHALL have parameter T1_CYC, default 4, meaning address/CS setup cycles before strobe (minimum 1).
REQ-002 SHALL have parameter T2_CYC, default 15, meaning strobe-active cycles (minimum 1).
REQ-003 SHALL have parameter TREC_CYC, default 12, meaning recovery cycles after strobe with CS released (minimum 1).
REQ-004 SHALL have parameter TMO_CYC, default 64, meaning maximum IORDY wait cycles.
REQ-005 SHALL have ports, one per line:
  clk  in  1  clock
  reset_n  in  1  asynchronous active-low reset
  av_address  in  4  bit3 selects cs_n[1], bits2:0 are the register address
  av_read  in  1  read request
  av_write  in  1  write request
  av_writedata  in  16  write data
  av_readdata  out  16  read data
  av_waitrequest  out  1  stall
  present  in  1  card present, debounced
  tmo_clr  in  1  clears tmo_err
  tmo_err  out  1  sticky IORDY timeout
  cs_n  out  2  ATA chip selects
  addr  out  3  ATA register address
  iord_n  out  1  read strobe
  iowr_n  out  1  write strobe
  data_out  out  16  pin write data
  data_oe  out  1  pin output enable
  data_in  in  16  pin read data
  iordy  in  1  device ready

Function
REQ-006 SHALL implement states IDLE, SETUP, STROBE, WAIT_RDY, HOLD and RECOVER.
REQ-007 IDLE SHALL accept a request when av_read or av_write is high: latch address, direction and writedata, then enter SETUP; av_read takes priority if both are high.
REQ-008 SHALL go from IDLE directly to HOLD when present is 0 at accept, with no strobe, cs_n held at 2'b11, and readdata 16'hFFFF.
REQ-009 SETUP SHALL last exactly T1_CYC cycles, with cs_n and addr driven from the latched address and both strobes high.
REQ-010 STROBE SHALL last exactly T2_CYC cycles, with iord_n or iowr_n low according to the latched direction.
REQ-011 On the last STROBE cycle, a read SHALL capture data_in into av_readdata and the FSM SHALL enter HOLD; this is subject to REQ-018.
REQ-012 HOLD SHALL last exactly 1 cycle, with strobes high and cs_n and addr still driven (address hold); av_waitrequest SHALL be 0 only in HOLD.
REQ-013 RECOVER SHALL last TREC_CYC cycles with cs_n at 2'b11; the FSM SHALL then return to IDLE.
REQ-014 av_waitrequest SHALL be 1 in every state other than HOLD, including IDLE.
REQ-015 data_oe SHALL be 1 for a write from SETUP through HOLD inclusive, and 0 otherwise; data_out SHALL hold the latched writedata.
REQ-016 A write SHALL leave av_readdata unchanged.
REQ-017 All pin outputs (cs_n, addr, iord_n, iowr_n, data_out, data_oe) SHALL be registered.
REQ-018 Total cycles from accept to HOLD SHALL equal T1_CYC + T2_CYC when no IORDY wait occurs.
REQ-019 tmo_err SHALL be cleared by tmo_clr; a set event in the same cycle SHALL win over tmo_clr.

Reset
REQ-020 Asynchronous reset SHALL force state IDLE, cs_n=2'b11, addr=0, iord_n=1, iowr_n=1, data_oe=0, data_out=0, av_readdata=0, av_waitrequest=1, tmo_err=0 and all counters to 0.
REQ-021 Reset asserted mid-transfer SHALL abort the transfer immediately; no completion cycle SHALL be issued.

Configuration
REQ-022 With macro CF_PIO_IORDY_EN defined, if iordy=0 on the last STROBE cycle the FSM SHALL enter WAIT_RDY.
REQ-023 In WAIT_RDY, strobes SHALL be held low; when iordy=1, read data SHALL be captured and the FSM SHALL enter HOLD.
REQ-024 In WAIT_RDY, after TMO_CYC cycles the FSM SHALL set tmo_err, load readdata with 16'hFFFF and enter HOLD.
REQ-025 Without CF_PIO_IORDY_EN, iordy SHALL be ignored, WAIT_RDY SHALL be unreachable and tmo_err SHALL be constant 0.

Structure
REQ-026 The state enumeration and default timing constants SHALL reside in the shared package cf_pkg.
REQ-027 A single sub-module cf_pio_cnt (loadable down-counter with zero flag) SHALL be used for the phase and timeout counts.

Verification
REQ-028 Read, defaults, present=1, address 4'h7, data_in=16'h50A1: cs_n=2'b10 for 4+15+1 cycles; iord_n low for 15 cycles; readdata=16'h50A1 in the single waitrequest-low cycle; next accept no earlier than 12 cycles later.
REQ-029 Write to address 4'hE, data 16'h1234: cs_n=2'b01, addr=3'h6, iowr_n low for 15 cycles, data_oe high for 20 cycles, data_out=16'h1234.
REQ-030 present=0, read: no strobe, cs_n stays 2'b11, waitrequest low on the cycle after accept, readdata=16'hFFFF.
REQ-031 With CF_PIO_IORDY_EN, iordy low for 10 cycles at strobe end: iord_n low for 25 cycles, correct data captured, tmo_err=0.
REQ-032 With CF_PIO_IORDY_EN, iordy stuck low: completes after 15+64 strobe cycles, readdata=16'hFFFF, tmo_err=1 until tmo_clr.
REQ-033 reset_n pulsed during STROBE: outputs return to reset values asynchronously; the next read completes normally.

Source files
------------

// File: rtl/cf_pkg.sv
// Shared constants for the CompactFlash PIO timing engine: FSM state codes,
// default timing values and the counter-width helper.
package cf_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SETUP    = 3'd1;
  localparam logic [2:0] ST_STROBE   = 3'd2;
  localparam logic [2:0] ST_WAIT_RDY = 3'd3;
  localparam logic [2:0] ST_HOLD     = 3'd4;
  localparam logic [2:0] ST_RECOVER  = 3'd5;

  localparam int CF_T1_DEF   = 4;
  localparam int CF_T2_DEF   = 15;
  localparam int CF_TREC_DEF = 12;
  localparam int CF_TMO_DEF  = 64;

  // Counters are loaded with (cycles - 1), so the widest phase needs $clog2(max) bits.
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m < 3) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/cf_pio_timing_if.sv
// Avalon-MM style register port of the CF PIO timing engine.
interface cf_pio_timing_if;
  // The master holds av_read/av_write (with address/data) until a cycle in which
  // av_waitrequest is low; that cycle completes the transfer and carries av_readdata.
  logic [3:0]  av_address;
  logic        av_read;
  logic        av_write;
  logic [15:0] av_writedata;
  logic [15:0] av_readdata;
  logic        av_waitrequest;

  modport master (
    output av_address, av_read, av_write, av_writedata,
    input  av_readdata, av_waitrequest
  );

  modport slave (
    input  av_address, av_read, av_write, av_writedata,
    output av_readdata, av_waitrequest
  );
endinterface

// File: rtl/cf_pio_cnt.sv
// Loadable down-counter with zero flag; saturates at zero.
module cf_pio_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/cf_pio_timing.sv
// CompactFlash PIO cycle generator: setup / strobe / hold / recovery sequencing.
// Optional IORDY wait-state and timeout support is enabled with CF_PIO_IORDY_EN.
module cf_pio_timing
  import cf_pkg::*;
#(
  parameter int T1_CYC   = CF_T1_DEF,
  parameter int T2_CYC   = CF_T2_DEF,
  parameter int TREC_CYC = CF_TREC_DEF,
  parameter int TMO_CYC  = CF_TMO_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  av_address,
  input  logic        av_read,
  input  logic        av_write,
  input  logic [15:0] av_writedata,
  output logic [15:0] av_readdata,
  output logic        av_waitrequest,
  input  logic        present,
  input  logic        tmo_clr,
  output logic        tmo_err,
  output logic [1:0]  cs_n,
  output logic [2:0]  addr,
  output logic        iord_n,
  output logic        iowr_n,
  output logic [15:0] data_out,
  output logic        data_oe,
  input  logic [15:0] data_in,
  input  logic        iordy,
  output logic [2:0]  dbg_state
);

  localparam int CNT_W = cnt_width(T1_CYC, T2_CYC, TREC_CYC, TMO_CYC);

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic             is_read;
  logic             accept;
  logic             rd_cap;
  logic             rd_ffff;
  logic             tmo_set;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic [CNT_W-1:0] cnt_unused;
  logic             cnt_zero;

  cf_pio_cnt #(.W(CNT_W)) u_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (1'b1),
    .count    (cnt_unused),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_val   = '0;
    accept    = 1'b0;
    rd_cap    = 1'b0;
    rd_ffff   = 1'b0;
    tmo_set   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (av_read || av_write) begin
          accept = 1'b1;
          if (present) begin
            state_nxt = ST_SETUP;
            cnt_load  = 1'b1;
            cnt_val   = CNT_W'(T1_CYC - 1);
          end else begin
            // No card: complete at once without touching the bus.
            state_nxt = ST_HOLD;
            rd_ffff   = av_read;
          end
        end
      end
      ST_SETUP: begin
        if (cnt_zero) begin
          state_nxt = ST_STROBE;
          cnt_load  = 1'b1;
          cnt_val   = CNT_W'(T2_CYC - 1);
        end
      end
      ST_STROBE: begin
        if (cnt_zero) begin
`ifdef CF_PIO_IORDY_EN
          if (!iordy) begin
            state_nxt = ST_WAIT_RDY;
            cnt_load  = 1'b1;
            cnt_val   = CNT_W'(TMO_CYC - 1);
          end else begin
            state_nxt = ST_HOLD;
            rd_cap    = is_read;
          end
`else
          state_nxt = ST_HOLD;
          rd_cap    = is_read;
`endif
        end
      end
`ifdef CF_PIO_IORDY_EN
      ST_WAIT_RDY: begin
        if (iordy) begin
          state_nxt = ST_HOLD;
          rd_cap    = is_read;
        end else if (cnt_zero) begin
          state_nxt = ST_HOLD;
          rd_ffff   = is_read;
          tmo_set   = 1'b1;
        end
      end
`endif
      ST_HOLD: begin
        state_nxt = ST_RECOVER;
        cnt_load  = 1'b1;
        cnt_val   = CNT_W'(TREC_CYC - 1);
      end
      ST_RECOVER: begin
        if (cnt_zero) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Pins are registered and updated on the transitions that change them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      is_read     <= 1'b0;
      cs_n        <= 2'b11;
      addr        <= 3'd0;
      iord_n      <= 1'b1;
      iowr_n      <= 1'b1;
      data_out    <= 16'd0;
      data_oe     <= 1'b0;
      av_readdata <= 16'd0;
    end else begin
      state <= state_nxt;
      if (accept) is_read <= av_read;
      if (accept && present) begin
        cs_n    <= av_address[3] ? 2'b01 : 2'b10;
        addr    <= av_address[2:0];
        data_oe <= !av_read;
        if (!av_read) data_out <= av_writedata;
      end
      if ((state == ST_SETUP) && (state_nxt == ST_STROBE)) begin
        iord_n <= !is_read;
        iowr_n <= is_read;
      end
      if (state_nxt == ST_HOLD) begin
        iord_n <= 1'b1;
        iowr_n <= 1'b1;
      end
      if (state == ST_HOLD) begin
        cs_n    <= 2'b11;
        data_oe <= 1'b0;
      end
      if (rd_cap) begin
        av_readdata <= data_in;
      end else if (rd_ffff) begin
        av_readdata <= 16'hFFFF;
      end
    end
  end

`ifdef CF_PIO_IORDY_EN
  // A timeout in the same cycle as tmo_clr must stay visible.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_err <= 1'b0;
    end else if (tmo_set) begin
      tmo_err <= 1'b1;
    end else if (tmo_clr) begin
      tmo_err <= 1'b0;
    end
  end
`else
  logic unused_iordy_path;
  assign unused_iordy_path = ^{iordy, tmo_clr, tmo_set};
  assign tmo_err           = 1'b0;
`endif

  assign av_waitrequest = (state != ST_HOLD);
  assign dbg_state      = state;

endmodule

// File: tb/tb_cf_pio_timing.sv
// Directed bench for cf_pio_timing: pin timing counts, read-data scoreboard,
// present/abort handling and, when CF_PIO_IORDY_EN is defined, IORDY wait/timeout.
module tb_cf_pio_timing;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        present, tmo_clr, tmo_err, iordy;
  logic [1:0]  cs_n;
  logic [2:0]  addr;
  logic        iord_n, iowr_n, data_oe;
  logic [15:0] data_out, data_in;
  logic [2:0]  dbg_state;

  cf_pio_timing_if av_if ();

  cf_pio_timing dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .av_address     (av_if.av_address),
    .av_read        (av_if.av_read),
    .av_write       (av_if.av_write),
    .av_writedata   (av_if.av_writedata),
    .av_readdata    (av_if.av_readdata),
    .av_waitrequest (av_if.av_waitrequest),
    .present        (present),
    .tmo_clr        (tmo_clr),
    .tmo_err        (tmo_err),
    .cs_n           (cs_n),
    .addr           (addr),
    .iord_n         (iord_n),
    .iowr_n         (iowr_n),
    .data_out       (data_out),
    .data_oe        (data_oe),
    .data_in        (data_in),
    .iordy          (iordy),
    .dbg_state      (dbg_state)
  );

  always #5 clk = ~clk;

  logic [15:0] exp_q[$];
  logic [15:0] model_rd, cur_wd;
  logic [1:0]  cs_seen;
  logic [2:0]  addr_seen;
  int n_compared = 0, n_mismatched = 0;
  int n_cyc, n_cs, n_rd, n_wr, n_oe, n_dout_bad, n_ack;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_stats();
    n_cyc = 0; n_cs = 0; n_rd = 0; n_wr = 0; n_oe = 0; n_dout_bad = 0; n_ack = 0;
    cs_seen = 2'b11; addr_seen = 3'd0;
  endtask

  // One cycle: outputs are sampled on the falling edge, away from the active edge.
  task automatic tick();
    @(negedge clk);
    n_cyc++;
    if (cs_n !== 2'b11) begin n_cs++; cs_seen = cs_n; addr_seen = addr; end
    if (iord_n === 1'b0) n_rd++;
    if (iowr_n === 1'b0) n_wr++;
    if (av_if.av_waitrequest === 1'b0) n_ack++;
    if (data_oe === 1'b1) begin
      n_oe++;
      if (data_out !== cur_wd) n_dout_bad++;
    end
  endtask

  task automatic post(input int n);
    repeat (n) tick();
  endtask

  task automatic start_req(input logic rd, input logic wr, input logic [3:0] a,
                           input logic [15:0] wd, input logic [15:0] din, input logic [15:0] exp);
    clr_stats();
    data_in  = din;
    cur_wd   = wd;
    exp_q.push_back(exp);
    model_rd = exp;
    av_if.av_read      = rd;
    av_if.av_write     = wr;
    av_if.av_address   = a;
    av_if.av_writedata = wd;
  endtask

  task automatic wait_hold(input int budget, input string tag, input bit keep);
    bit done;
    logic [15:0] e;
    done = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      tick();
      if (av_if.av_waitrequest === 1'b0) done = 1'b1;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    if (!keep) begin av_if.av_read = 1'b0; av_if.av_write = 1'b0; end
    check({tag, "_sbq"}, 32'(exp_q.size()), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_rdata"}, 32'(av_if.av_readdata), 32'(e));
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cs"},    32'(cs_n), 32'h3);
    check({tag, "_addr"},  32'(addr), 32'h0);
    check({tag, "_iord"},  32'(iord_n), 32'h1);
    check({tag, "_iowr"},  32'(iowr_n), 32'h1);
    check({tag, "_oe"},    32'(data_oe), 32'h0);
    check({tag, "_dout"},  32'(data_out), 32'h0);
    check({tag, "_rdata"}, 32'(av_if.av_readdata), 32'h0);
    check({tag, "_wreq"},  32'(av_if.av_waitrequest), 32'h1);
    check({tag, "_tmo"},   32'(tmo_err), 32'h0);
    check({tag, "_state"}, 32'(dbg_state), 32'h0);
  endtask

  initial begin
    int k;
    reset_n = 1'b0; present = 1'b1; iordy = 1'b1; tmo_clr = 1'b0; data_in = 16'd0;
    av_if.av_read = 1'b0; av_if.av_write = 1'b0; av_if.av_address = 4'd0; av_if.av_writedata = 16'd0;
    model_rd = 16'd0; cur_wd = 16'd0;
    clr_stats();
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // Default read of address 7.
    start_req(1'b1, 1'b0, 4'h7, 16'd0, 16'h50A1, 16'h50A1);
    wait_hold(60, "rd7", 1'b0);
    check("rd7_lat", 32'(n_cyc), 32'd20);
    post(13);
    check("rd7_cs_cyc", 32'(n_cs), 32'd20);
    check("rd7_iord_cyc", 32'(n_rd), 32'd15);
    check("rd7_iowr_cyc", 32'(n_wr), 32'd0);
    check("rd7_oe_cyc", 32'(n_oe), 32'd0);
    check("rd7_cs_val", 32'(cs_seen), 32'h2);
    check("rd7_addr_val", 32'(addr_seen), 32'h7);
    check("rd7_ack_cyc", 32'(n_ack), 32'd1);

    // Request held through recovery: next accept only after recovery plus the idle cycle.
    start_req(1'b1, 1'b0, 4'h3, 16'd0, 16'h0F0F, 16'h0F0F);
    wait_hold(60, "b2b_a", 1'b1);
    data_in = 16'hA55A;
    exp_q.push_back(16'hA55A);
    model_rd = 16'hA55A;
    k = 0;
    do begin tick(); k++; end while (cs_n === 2'b11 && k < 40);
    check("b2b_gap", 32'(k), 32'd14);
    wait_hold(60, "b2b_b", 1'b0);
    post(13);

    // Write to address E.
    start_req(1'b0, 1'b1, 4'hE, 16'h1234, 16'hDEAD, model_rd);
    wait_hold(60, "wrE", 1'b0);
    check("wrE_lat", 32'(n_cyc), 32'd20);
    post(13);
    check("wrE_cs_val", 32'(cs_seen), 32'h1);
    check("wrE_addr_val", 32'(addr_seen), 32'h6);
    check("wrE_iowr_cyc", 32'(n_wr), 32'd15);
    check("wrE_iord_cyc", 32'(n_rd), 32'd0);
    check("wrE_oe_cyc", 32'(n_oe), 32'd20);
    check("wrE_dout_bad", 32'(n_dout_bad), 32'd0);
    check("wrE_dout", 32'(data_out), 32'h1234);

    // Card absent: read and write complete without bus activity.
    present = 1'b0;
    start_req(1'b1, 1'b0, 4'h5, 16'd0, 16'h1111, 16'hFFFF);
    wait_hold(10, "abs_rd", 1'b0);
    check("abs_rd_lat", 32'(n_cyc), 32'd1);
    post(13);
    check("abs_rd_cs_cyc", 32'(n_cs), 32'd0);
    check("abs_rd_iord_cyc", 32'(n_rd), 32'd0);
    start_req(1'b0, 1'b1, 4'h9, 16'hBEEF, 16'h2222, model_rd);
    wait_hold(10, "abs_wr", 1'b0);
    post(13);
    check("abs_wr_oe_cyc", 32'(n_oe), 32'd0);
    check("abs_wr_iowr_cyc", 32'(n_wr), 32'd0);
    present = 1'b1;

    // Read wins when both requests are raised.
    start_req(1'b1, 1'b1, 4'hB, 16'h9999, 16'h6B6B, 16'h6B6B);
    wait_hold(60, "both", 1'b0);
    post(13);
    check("both_iord_cyc", 32'(n_rd), 32'd15);
    check("both_iowr_cyc", 32'(n_wr), 32'd0);
    check("both_oe_cyc", 32'(n_oe), 32'd0);
    check("both_cs_val", 32'(cs_seen), 32'h1);

    // Random transfers.
    for (int i = 0; i < 4; i++) begin
      logic rd;
      logic [3:0] a;
      logic [15:0] wd, din;
      rd  = 1'($urandom_range(0, 1));
      a   = 4'($urandom_range(0, 15));
      wd  = 16'($urandom_range(0, 65535));
      din = 16'($urandom_range(0, 65535));
      start_req(rd, !rd, a, wd, din, rd ? din : model_rd);
      wait_hold(60, "rand", 1'b0);
      post(13);
      check("rand_cs_val", 32'(cs_seen), a[3] ? 32'h1 : 32'h2);
      check("rand_addr_val", 32'(addr_seen), 32'(a[2:0]));
      check("rand_strb_cyc", rd ? 32'(n_rd) : 32'(n_wr), 32'd15);
      check("rand_oe_cyc", 32'(n_oe), rd ? 32'd0 : 32'd20);
    end

    // Reset pulsed in the middle of the strobe.
    start_req(1'b1, 1'b0, 4'h2, 16'd0, 16'h7777, 16'h7777);
    for (int j = 0; j < 40 && n_rd < 5; j++) tick();
    reset_n = 1'b0;
    #1;
    check_reset_vals("rst_mid");
    av_if.av_read = 1'b0;
    exp_q.delete();
    model_rd = 16'd0;
    @(negedge clk);
    reset_n = 1'b1;
    clr_stats();
    post(5);
    check("rst_mid_no_ack", 32'(n_ack), 32'd0);
    check("rst_mid_no_cs", 32'(n_cs), 32'd0);
    start_req(1'b1, 1'b0, 4'h7, 16'd0, 16'hC3A5, 16'hC3A5);
    wait_hold(60, "rst_next", 1'b0);
    check("rst_next_lat", 32'(n_cyc), 32'd20);
    post(13);
    check("rst_next_iord_cyc", 32'(n_rd), 32'd15);

`ifdef CF_PIO_IORDY_EN
    // IORDY low on the last strobe cycle and nine wait cycles after it.
    iordy = 1'b0;
    start_req(1'b1, 1'b0, 4'h1, 16'd0, 16'h3C3C, 16'h3C3C);
    for (int j = 0; j < 60 && n_rd < 25; j++) tick();
    iordy = 1'b1;
    wait_hold(20, "rdy10", 1'b0);
    check("rdy10_iord_cyc", 32'(n_rd), 32'd25);
    check("rdy10_lat", 32'(n_cyc), 32'd30);
    check("rdy10_tmo", 32'(tmo_err), 32'd0);
    post(13);

    // IORDY stuck low: timeout, sticky error until cleared.
    iordy = 1'b0;
    start_req(1'b1, 1'b0, 4'h4, 16'd0, 16'h2222, 16'hFFFF);
    wait_hold(120, "stuck", 1'b0);
    check("stuck_iord_cyc", 32'(n_rd), 32'd79);
    check("stuck_lat", 32'(n_cyc), 32'd84);
    check("stuck_tmo", 32'(tmo_err), 32'd1);
    post(13);
    check("stuck_tmo_sticky", 32'(tmo_err), 32'd1);
    tmo_clr = 1'b1;
    @(negedge clk);
    tmo_clr = 1'b0;
    check("tmo_clr", 32'(tmo_err), 32'd0);

    // Clear held high across a timeout: the set in that cycle wins.
    tmo_clr = 1'b1;
    start_req(1'b1, 1'b0, 4'hC, 16'd0, 16'h4444, 16'hFFFF);
    wait_hold(120, "stuck_clr", 1'b0);
    check("set_wins", 32'(tmo_err), 32'd1);
    tick();
    check("clr_after_set", 32'(tmo_err), 32'd0);
    tmo_clr = 1'b0;
    iordy = 1'b1;
    post(12);
`else
    // IORDY ignored in this build.
    iordy = 1'b0;
    start_req(1'b1, 1'b0, 4'h1, 16'd0, 16'h3C3C, 16'h3C3C);
    wait_hold(60, "noRdy", 1'b0);
    check("noRdy_lat", 32'(n_cyc), 32'd20);
    check("noRdy_tmo", 32'(tmo_err), 32'd0);
    post(13);
    check("noRdy_iord_cyc", 32'(n_rd), 32'd15);
    iordy = 1'b1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, required end before 200000");
    $fatal(1, "watchdog");
  end

endmodule
